// File: rtl/memory_responder_pkg.sv
// Shared types for the backing-store responder: request operation/size encodings,
// word geometry, default response latency and the responder FSM state encoding.
package memory_responder_pkg;

    localparam int WORD_BITS           = 32;
    localparam int BYTES_PER_WORD      = WORD_BITS / 8;
    localparam int MEM_LATENCY_DEFAULT = 2;

    typedef enum logic {
        LOAD  = 1'b0,
        STORE = 1'b1
    } memory_operation_e;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } memory_operation_size_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_RESPOND = 2'd2
    } responder_state_e;

    // Countdown width for a given latency; a latency of 1 still needs a 1-bit register.
    function automatic int latency_cnt_width(input int latency);
        return (latency > 1) ? $clog2(latency) : 1;
    endfunction

endpackage

// File: rtl/memory_responder_byte_enable_gen.sv
// Combinational lane decoder: (size, addr[1:0]) -> little-endian lane mask plus the
// store data replicated so every enabled lane sees its byte; zero latency, no flow control.
module byte_enable_gen
    import memory_responder_pkg::*;
(
    input  memory_operation_size_e      size,
    input  logic [1:0]                  addr_lo,
    input  logic [WORD_BITS-1:0]        store_word,
    output logic [BYTES_PER_WORD-1:0]   lane_mask,
    output logic [WORD_BITS-1:0]        lane_word
);

    always_comb begin
        lane_mask = '0;
        lane_word = store_word;
        case (size)
            BYTE: begin
                lane_mask = 4'b0001 << addr_lo;
                lane_word = {4{store_word[7:0]}};
            end
            HALF: begin
                // addr_lo[0] is ignored: halves are always lane-pair aligned
                lane_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
                lane_word = {2{store_word[15:0]}};
            end
            WORD: begin
                lane_mask = 4'b1111;
            end
            default: begin
                lane_mask = '0;
            end
        endcase
    end

endmodule

// File: rtl/memory_responder.sv
// Word-organised backing store answering a valid/fulfilled requester with a fixed LATENCY;
// one request per LATENCY+1 cycles, requester holds fields until the one-cycle fulfilled pulse.
module memory_responder
    import memory_responder_pkg::*;
#(
    parameter int    XLEN      = WORD_BITS,
    parameter int    MEM_SIZE  = 4096,
    parameter int    LATENCY   = MEM_LATENCY_DEFAULT,
    parameter string INIT_FILE = ""
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   req_valid,
    input  memory_operation_e      req_operation,
    input  memory_operation_size_e req_size,
    input  logic [XLEN-1:0]        req_address,
    input  logic [XLEN-1:0]        req_store_word,
    output logic [XLEN-1:0]        req_loaded_word,
    output logic                   req_fulfilled
);

    localparam int DEPTH = MEM_SIZE / BYTES_PER_WORD;
    localparam int AW    = $clog2(MEM_SIZE);
    localparam int CW    = latency_cnt_width(LATENCY);

    if (XLEN != WORD_BITS) begin : g_bad_xlen
        $error("memory_responder: XLEN must be %0d", WORD_BITS);
    end
    if (LATENCY < 1) begin : g_bad_latency
        $error("memory_responder: LATENCY must be >= 1");
    end
    if (((MEM_SIZE & (MEM_SIZE - 1)) != 0) || ((MEM_SIZE % BYTES_PER_WORD) != 0)) begin : g_bad_size
        $error("memory_responder: MEM_SIZE must be a power of two and a multiple of the word size");
    end

    logic [XLEN-1:0]           mem [DEPTH];

    responder_state_e          state;
    responder_state_e          state_nxt;
    logic [CW-1:0]             cnt;
    logic [CW-1:0]             cnt_nxt;
    logic                      load_capture;
    logic                      store_commit;
    logic [AW-3:0]             word_idx;
    logic [BYTES_PER_WORD-1:0] lane_mask;
    logic [XLEN-1:0]           lane_word;
    logic                      addr_unused;

    // Addresses wrap modulo MEM_SIZE, so the bits above the array are dropped.
    assign word_idx    = req_address[AW-1:2];
    assign addr_unused = &{1'b0, req_address[XLEN-1:AW]};

    byte_enable_gen u_byte_enable_gen (
        .size       (req_size),
        .addr_lo    (req_address[1:0]),
        .store_word (req_store_word),
        .lane_mask  (lane_mask),
        .lane_word  (lane_word)
    );

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        req_fulfilled = 1'b0;
        case (state)
            ST_IDLE: begin
                if (req_valid) begin
                    cnt_nxt   = CW'(LATENCY - 1);
                    state_nxt = (LATENCY == 1) ? ST_RESPOND : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (!req_valid) begin
                    cnt_nxt   = '0;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt - 1'b1;
                    if (cnt <= CW'(1)) begin
                        state_nxt = ST_RESPOND;
                    end
                end
            end
            ST_RESPOND: begin
                // A requester that abandons the request here gets neither pulse nor write.
                req_fulfilled = req_valid;
                cnt_nxt       = '0;
                state_nxt     = ST_IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = ST_IDLE;
            end
        endcase
        load_capture = (state_nxt == ST_RESPOND) && (req_operation == LOAD);
        store_commit = (state == ST_RESPOND) && req_valid && (req_operation == STORE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= ST_IDLE;
            cnt             <= '0;
            req_loaded_word <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            // Captured on entry to RESPOND so the data is valid alongside the pulse.
            if (load_capture) begin
                req_loaded_word <= mem[word_idx];
            end
        end
    end

    // Contents survive reset.
    always_ff @(posedge clk) begin
        if (store_commit) begin
            for (int i = 0; i < BYTES_PER_WORD; i++) begin
                if (lane_mask[i]) begin
                    mem[word_idx][i*8 +: 8] <= lane_word[i*8 +: 8];
                end
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (reset_n && (state != ST_IDLE) && !req_valid) begin
            $warning("memory_responder: req_valid dropped before req_fulfilled at %0t", $time);
        end
    end
`endif

endmodule

// File: doc/memory_responder.md
# memory_responder

- Backing-store model and server end of `memory_if`.
- Sits above the lowest cache level and answers its `hmem_if` requester port: word-granular line fills and dirty-line writebacks, each under a valid/fulfilled handshake.
- Single-port, word-organised array with a parameterised fixed response latency and a small FSM.
- Used in simulation and as the default main memory of the SoC top.

## Interface
Parameters:
- `XLEN`, 32: data/address width; only `` `WORD `` is supported, `$error` otherwise.
- `MEM_SIZE`, 4096: capacity in bytes; power of two, multiple of `` `BYTES_PER_WORD ``.
- `LATENCY`, 2: cycles from request acceptance to `req_fulfilled`; must be ≥1, `$error` otherwise.
- `INIT_FILE`, "": optional `$readmemh` image, word per line, loaded at time 0.

Ports (signals of the `memory_if.server` modport `req_if`, plus clock and reset):
- `clk`  in  1  sole clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `req_if.req_valid`  in  1  request present.
- `req_if.req_operation`  in  `memory_operation_e`  LOAD or STORE.
- `req_if.req_size`  in  `memory_operation_size_e`  BYTE, HALF or WORD.
- `req_if.req_address`  in  XLEN  byte address.
- `req_if.req_store_word`  in  XLEN  store data, right-justified.
- `req_if.req_loaded_word`  out  XLEN  load data.
- `req_if.req_fulfilled`  out  1  one-cycle completion pulse.

## Operation
FSM states: IDLE, WAIT, RESPOND.
- IDLE: if `req_valid` is 1, load the latency counter with `LATENCY-1`.
  - Go to RESPOND if `LATENCY==1`, otherwise WAIT.
- WAIT: decrement the counter each cycle; at 0, go to RESPOND.
- RESPOND: drive `req_fulfilled`=1 for exactly one cycle, then return to IDLE.
- Requester rule: all request fields are held stable from the `req_valid` rise until the `req_fulfilled` cycle inclusive.
- The requester may keep `req_valid` high with new fields on the cycle after `req_fulfilled`. Burst fills and writebacks work this way.
- Dropping `req_valid` during WAIT or RESPOND is a protocol violation. Required behaviour:
  - Return to IDLE next cycle.
  - No write, no pulse.
  - Flag it with a simulation-only `$warning`.
- Addressing:
  - Word index is `req_address[log2(MEM_SIZE)-1:2]`.
  - Upper address bits are ignored, so addresses wrap modulo MEM_SIZE.
- LOAD: `req_loaded_word` gets the full aligned word containing the address, regardless of `req_size`. The requester extracts the bytes it needs.
- STORE: little-endian byte-lane write, committed on the RESPOND edge.
  - BYTE: lane `addr[1:0]` gets `store_word[7:0]`.
  - HALF: lanes `{addr[1],0}` and `{addr[1],1}` get `store_word[15:0]`; `addr[0]` is ignored.
  - WORD: all four lanes; `addr[1:0]` are ignored.
- STORE leaves `req_loaded_word` unchanged.

## Timing
- Reset values (asynchronous assert):
  - state IDLE, counter 0.
  - `req_fulfilled` 0, `req_loaded_word` 0.
- Memory contents are not cleared by reset. Only `INIT_FILE` initialises them, at time 0.
- Reset mid-request: the request is discarded, no write occurs, and the FSM is in IDLE on the first edge after `reset_n` rises.
- Latency:
  - `req_valid` first seen high at edge N gives `req_fulfilled` high during cycle N+LATENCY.
  - At `LATENCY=1` the pulse is in the cycle after acceptance.
- Back-to-back requests:
  - The earliest next acceptance is the edge ending the RESPOND cycle.
  - Throughput is one request per LATENCY+1 cycles.
- `req_loaded_word` is registered:
  - It is valid during the `req_fulfilled` cycle.
  - It holds that value until the next LOAD completes.
- Load-after-store to the same word returns the stored data, because the write commits before the next acceptance.

## Structure
- `torrence_types` (existing) holds `memory_operation_e` and `memory_operation_size_e`. Add `MEM_LATENCY_DEFAULT` there as well.
- `` `WORD `` and `` `BYTES_PER_WORD `` come from `macros.svh`.
- One sub-module, `byte_enable_gen`: combinational; maps (`req_size`, `addr[1:0]`) to a 4-bit lane mask and the lane-aligned store word.
- Reuse `counter` (`count_down`) for the latency countdown.

## Test plan
- **Reset state:** `reset_n` low for 3 cycles → `req_fulfilled`=0, `req_loaded_word`=0, no response while idle.
- **Word store then load:**
  - WORD store 0xDEADBEEF @0x40, LATENCY=2 → pulse exactly 2 cycles after acceptance.
  - LOAD @0x40 → 0xDEADBEEF.
- **Sub-word stores:**
  - Start from WORD 0x11223344 @0x80.
  - BYTE store 0xAA @0x81 → word reads 0x1122AA44.
  - HALF store 0xBEEF @0x83 → word reads 0xBEEFAA44.
- **Burst and wrap:**
  - 8 consecutive LOADs @0x100–0x11C with `req_valid` held high → 8 pulses spaced LATENCY+1 cycles, data matches the INIT_FILE image.
  - Address 0x1000+0x40 returns the same word as 0x40.
- **Reset mid-request:** STORE 0x55 @0x20 with `reset_n` dropped in WAIT → no pulse; LOAD @0x20 afterwards returns the prior contents.
- **Protocol violation and LATENCY=1:**
  - `req_valid` dropped in WAIT → no pulse, no write, IDLE next cycle.
  - Rerun at LATENCY=1 → pulse the cycle after acceptance.
